// File: rtl/timer_irq_sequencer_if.sv
// Avalon-MM link between the sequencer (master) and the interval timer s1 port (slave),
// including the timer's level interrupt.
interface timer_irq_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/timer_irq_sequencer.sv
// Drives an interval timer through its register port: loads the period, starts it,
// clears timeouts on IRQ, counts them, and reads back counter snapshots on request.
module timer_irq_sequencer #(
  parameter int EVENT_W        = 16,
  parameter bit CLEAR_ON_START = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_start,
  input  logic [31:0]            cmd_period,
  input  logic                   cmd_continuous,
  input  logic                   cmd_stop,
  input  logic                   snap_req,
  output logic                   busy,
  output logic                   running,
  output logic                   tick,
  output logic [EVENT_W-1:0]     event_count,
  output logic [31:0]            snap_value,
  output logic                   snap_valid,
  timer_irq_sequencer_if.master  avm
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTRL,
    S_RUN,
    S_CLR_TO,
    S_SNAP_WR,
    S_SNAP_RDL,
    S_SNAP_CAPL,
    S_SNAP_RDH,
    S_SNAP_CAPH,
    S_WR_STOP,
    S_STOP_CLR
  } state_t;

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_PERL   = 3'd2;
  localparam logic [2:0] A_PERH   = 3'd3;
  localparam logic [2:0] A_SNAPL  = 3'd4;
  localparam logic [2:0] A_SNAPH  = 3'd5;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] period_q;
  logic        cont_q;
  logic        stop_pending;
  logic        start_accept;

  assign start_accept = (state == S_IDLE) && cmd_start;
  assign busy         = (state != S_IDLE);
  assign running      = !(state inside {S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL});

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    avm.chipselect = 1'b0;
    avm.write_n    = 1'b1;
    avm.address    = A_STATUS;
    avm.writedata  = 16'h0000;
    tick           = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_start) state_nxt = S_WR_PL;
      end
      S_WR_PL: begin
        avm.chipselect = 1'b1;
        avm.write_n    = 1'b0;
        avm.address    = A_PERL;
        avm.writedata  = period_q[15:0];
        state_nxt      = S_WR_PH;
      end
      S_WR_PH: begin
        avm.chipselect = 1'b1;
        avm.write_n    = 1'b0;
        avm.address    = A_PERH;
        avm.writedata  = period_q[31:16];
        state_nxt      = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        // control = {stop, start, cont, ito}
        avm.chipselect = 1'b1;
        avm.write_n    = 1'b0;
        avm.address    = A_CTRL;
        avm.writedata  = {12'h000, 1'b0, 1'b1, cont_q, 1'b1};
        state_nxt      = S_RUN;
      end
      S_RUN: begin
        if (cmd_stop || stop_pending) state_nxt = S_WR_STOP;
        else if (avm.irq)             state_nxt = S_CLR_TO;
        else if (snap_req)            state_nxt = S_SNAP_WR;
      end
      S_CLR_TO: begin
        avm.chipselect = 1'b1;
        avm.write_n    = 1'b0;
        avm.address    = A_STATUS;
        tick           = 1'b1;
        state_nxt      = cont_q ? S_RUN : S_IDLE;
      end
      S_SNAP_WR: begin
        avm.chipselect = 1'b1;
        avm.write_n    = 1'b0;
        avm.address    = A_SNAPL;
        state_nxt      = S_SNAP_RDL;
      end
      S_SNAP_RDL: begin
        avm.chipselect = 1'b1;
        avm.address    = A_SNAPL;
        state_nxt      = S_SNAP_CAPL;
      end
      S_SNAP_CAPL: state_nxt = S_SNAP_RDH;
      S_SNAP_RDH: begin
        avm.chipselect = 1'b1;
        avm.address    = A_SNAPH;
        state_nxt      = S_SNAP_CAPH;
      end
      S_SNAP_CAPH: state_nxt = S_RUN;
      S_WR_STOP: begin
        avm.chipselect = 1'b1;
        avm.write_n    = 1'b0;
        avm.address    = A_CTRL;
        avm.writedata  = 16'h0008;
        state_nxt      = S_STOP_CLR;
      end
      S_STOP_CLR: begin
        avm.chipselect = 1'b1;
        avm.write_n    = 1'b0;
        avm.address    = A_STATUS;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command operands are held for the whole start sequence and the run that follows.
  always_ff @(posedge clk) begin
    if (start_accept) begin
      period_q <= cmd_period;
      cont_q   <= cmd_continuous;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      event_count  <= '0;
      snap_value   <= '0;
      snap_valid   <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      snap_valid <= (state == S_SNAP_CAPH);
      if (start_accept && CLEAR_ON_START) event_count <= '0;
      else if (state == S_CLR_TO)         event_count <= event_count + EVENT_W'(1);
      if (state == S_SNAP_CAPL) snap_value[15:0]  <= avm.readdata;
      if (state == S_SNAP_CAPH) snap_value[31:16] <= avm.readdata;
      // A stop that lands mid-sequence waits for RUN; once back in IDLE there is nothing left to stop.
      if (state_nxt == S_WR_STOP || state_nxt == S_IDLE)
        stop_pending <= 1'b0;
      else if (cmd_stop && state != S_IDLE && state != S_RUN)
        stop_pending <= 1'b1;
    end
  end

endmodule
